// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone word-copy master.
// WB_COPY_CHECKSUM_EN adds a running checksum of the copied words.
package wb_copy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP,
    S_FIN
  } state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  localparam int DEF_ADR_STEP    = 4;
  localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/wb_copy_master_timeout.sv
// Wait-state counter for the copy master; expired flags the last
// allowed stalled cycle. TIMEOUT_CYC = 0 disables the counter.
module wb_timeout_cnt
  import wb_copy_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused;
      assign unused  = ^{clk, rst, clr, en};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT_CYC + 1);
      logic [W-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + W'(1);
        end
      end

      // true during the stalled cycle that brings the count to the limit
      assign expired = en && (cnt == W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone classic initiator copying cmd_len words src -> dst.
// Define WB_COPY_CHECKSUM_EN to add the checksum_o output.
module wb_copy_master
  import wb_copy_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int ADR_STEP    = DEF_ADR_STEP
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
`ifdef WB_COPY_CHECKSUM_EN
  ,
  output logic [31:0]      checksum_o
`endif
);

  state_t           state, state_n;
  logic [31:0]      cur_src, cur_dst, data;
  logic [LEN_W-1:0] remaining;
  logic             err_q;
  logic             accept, ack, expired;

  assign accept = (state == S_IDLE) && cmd_valid;
  assign ack    = wbm_stb_o && wbm_ack_i;

  wb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (!wbm_stb_o),
    .en     (wbm_stb_o && !wbm_ack_i),
    .expired(expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_n = (cmd_len == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        if (ack) state_n = S_RD_GAP;
        else if (expired) state_n = S_IDLE;
      end
      S_RD_GAP: state_n = S_WR;
      S_WR: begin
        if (ack) state_n = S_WR_GAP;
        else if (expired) state_n = S_IDLE;
      end
      S_WR_GAP: begin
        state_n = (remaining == '0) ? S_FIN : S_RD;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy_o    = (state != S_IDLE);
  assign done_o    = (state == S_FIN);
  assign err_o     = err_q;
  assign wbm_stb_o = (state == S_RD) || (state == S_WR);
  assign wbm_cyc_o = wbm_stb_o;
  assign wbm_we_o  = (state == S_WR);
  assign wbm_sel_o = wbm_stb_o ? WB_SEL_ALL : 4'h0;
  assign wbm_dat_o = data;

  always_comb begin
    wbm_adr_o = 32'h0;
    unique case (1'b1)
      state == S_RD: wbm_adr_o = cur_src;
      state == S_WR: wbm_adr_o = cur_dst;
      default:       wbm_adr_o = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      data      <= '0;
      err_q     <= 1'b0;
    end else begin
      // a late ack beats the limit, so only stalled strobes abort
      err_q <= wbm_stb_o && expired;
      if (accept) begin
        cur_src   <= cmd_src;
        cur_dst   <= cmd_dst;
        remaining <= cmd_len;
      end
      if (state == S_RD && ack) begin
        data <= wbm_dat_i;
      end
      if (state == S_WR && ack) begin
        cur_src   <= cur_src + 32'(ADR_STEP);
        cur_dst   <= cur_dst + 32'(ADR_STEP);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

`ifdef WB_COPY_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (state == S_WR && ack) begin
      csum <= csum + data;
    end
  end

  assign checksum_o = csum;
`endif

endmodule
